// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - control FSM turning keypad events into calculator datapath strobes
module calc_sequencer #(
    parameter int OPW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inDigitValid,
    input  logic           inOpValid,
    input  logic [OPW-1:0] inOpCode,
    input  logic           inEquals,
    input  logic           inClear,
    output logic           outRegLoad,
    output logic           outMuxSelect,
    output logic           outAccLoad,
    output logic           outAccClear,
    output logic [OPW-1:0] outAluOp,
    output logic           outBusy,
    output logic           outDone,
    output logic [7:0]     outOpCount
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, WAIT_OP, WAIT_B, WAIT_EQ, EXEC, WRITE, DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(ALU_LAT - 1);

    state_t         state;
    state_t         stateNext;
    logic [OPW-1:0] latchedOp;
    logic [OPW-1:0] pendingOp;
    logic           pendingValid;
    logic [3:0]     waitCnt;
    logic [7:0]     opCount;
    logic           accClearQ;

    logic           latchOp;
    logic           setPending;
    logic           dropPending;
    logic           promotePending;

    // Priority-resolved events: a higher-priority key in the same cycle masks the rest
    logic evClear, evEquals, evOp, evDigit;
    assign evClear  = inClear;
    assign evEquals = inEquals & ~inClear;
    assign evOp     = inOpValid & ~inEquals & ~inClear;
    assign evDigit  = inDigitValid & ~inOpValid & ~inEquals & ~inClear;

    // Next-state decode plus the Mealy input-register load and op bookkeeping strobes
    always_comb begin
        stateNext      = state;
        outRegLoad     = 1'b0;
        latchOp        = 1'b0;
        setPending     = 1'b0;
        dropPending    = 1'b0;
        promotePending = 1'b0;
        if (evClear) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (evDigit) begin
                        outRegLoad = 1'b1;
                        stateNext  = LOAD_A;
                    end
                end
                LOAD_A: stateNext = WAIT_OP;
                WAIT_OP: begin
                    if (evOp) begin
                        latchOp   = 1'b1;
                        stateNext = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (evDigit) begin
                        outRegLoad = 1'b1;
                        stateNext  = WAIT_EQ;
                    end else if (evOp) begin
                        latchOp = 1'b1;
                    end
                end
                WAIT_EQ: begin
                    if (evEquals) begin
                        dropPending = 1'b1;
                        stateNext   = EXEC;
                    end else if (evOp) begin
                        setPending = 1'b1;
                        stateNext  = EXEC;
                    end else if (evDigit) begin
                        outRegLoad = 1'b1;
                    end
                end
                EXEC: begin
                    if (waitCnt == WAIT_LAST) stateNext = WRITE;
                end
                WRITE: begin
                    if (pendingValid) begin
                        promotePending = 1'b1;
                        stateNext      = WAIT_B;
                    end else begin
                        stateNext = DONE;
                    end
                end
                DONE: begin
                    if (evOp) begin
                        latchOp   = 1'b1;
                        stateNext = WAIT_B;
                    end else if (evDigit) begin
                        outRegLoad = 1'b1;
                        stateNext  = LOAD_A;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, op latches, ALU wait counter and saturating operation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            latchedOp    <= '0;
            pendingOp    <= '0;
            pendingValid <= 1'b0;
            waitCnt      <= 4'd0;
            opCount      <= 8'd0;
            accClearQ    <= 1'b0;
        end else begin
            state     <= stateNext;
            accClearQ <= evClear;
            if (evClear) begin
                latchedOp    <= '0;
                pendingOp    <= '0;
                pendingValid <= 1'b0;
                waitCnt      <= 4'd0;
                opCount      <= 8'd0;
            end else begin
                waitCnt <= (state == EXEC && stateNext == EXEC) ? waitCnt + 4'd1 : 4'd0;
                if (latchOp) latchedOp <= inOpCode;
                if (dropPending) begin
                    pendingOp    <= '0;
                    pendingValid <= 1'b0;
                end
                if (setPending) begin
                    pendingOp    <= inOpCode;
                    pendingValid <= 1'b1;
                end
                if (promotePending) begin
                    latchedOp    <= pendingOp;
                    pendingOp    <= '0;
                    pendingValid <= 1'b0;
                end
                if (state == WRITE && opCount != 8'hFF) opCount <= opCount + 8'd1;
            end
        end
    end

    // Moore outputs; the clear strobe always lands in IDLE, so the load mask is a safety net
    assign outAccClear  = accClearQ;
    assign outAccLoad   = (state == LOAD_A || state == WRITE) && !accClearQ;
    assign outMuxSelect = (state == EXEC || state == WRITE);
    assign outBusy      = (state == EXEC || state == WRITE);
    assign outDone      = (state == DONE);
    assign outAluOp     = (state == IDLE) ? '0 : latchedOp;
    assign outOpCount   = opCount;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

    localparam int OPW = 2;
    localparam int LAT = 3;

    logic           clk;
    logic           rst_n;
    logic           inDigitValid;
    logic           inOpValid;
    logic [OPW-1:0] inOpCode;
    logic           inEquals;
    logic           inClear;
    logic           outRegLoad;
    logic           outMuxSelect;
    logic           outAccLoad;
    logic           outAccClear;
    logic [OPW-1:0] outAluOp;
    logic           outBusy;
    logic           outDone;
    logic [7:0]     outOpCount;

    int numChecks = 0;
    int numFails  = 0;

    calc_sequencer #(.OPW(OPW), .ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inDigitValid (inDigitValid),
        .inOpValid    (inOpValid),
        .inOpCode     (inOpCode),
        .inEquals     (inEquals),
        .inClear      (inClear),
        .outRegLoad   (outRegLoad),
        .outMuxSelect (outMuxSelect),
        .outAccLoad   (outAccLoad),
        .outAccClear  (outAccClear),
        .outAluOp     (outAluOp),
        .outBusy      (outBusy),
        .outDone      (outDone),
        .outOpCount   (outOpCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleInputs();
        inDigitValid = 1'b0;
        inOpValid    = 1'b0;
        inOpCode     = '0;
        inEquals     = 1'b0;
        inClear      = 1'b0;
    endtask

    task automatic doDigit();
        inDigitValid = 1'b1;
        tick();
        idleInputs();
    endtask

    task automatic doOp(input logic [OPW-1:0] code);
        inOpValid = 1'b1;
        inOpCode  = code;
        tick();
        idleInputs();
    endtask

    task automatic doEquals();
        inEquals = 1'b1;
        tick();
        idleInputs();
    endtask

    task automatic doClear();
        inClear = 1'b1;
        tick();
        idleInputs();
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        #12;
        checkEq("rst_regload",  {15'd0, outRegLoad},   16'd0);
        checkEq("rst_accload",  {15'd0, outAccLoad},   16'd0);
        checkEq("rst_accclear", {15'd0, outAccClear},  16'd0);
        checkEq("rst_busy_done", {14'd0, outBusy, outDone}, 16'd0);
        checkEq("rst_opcount",  {8'd0, outOpCount},    16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single calculation: digit, op=01, digit, equals
        inDigitValid = 1'b1;
        #1 checkEq("idle_digit_regload", {15'd0, outRegLoad}, 16'd1);
        tick();
        idleInputs();
        checkEq("loada_accload", {15'd0, outAccLoad},   16'd1);
        checkEq("loada_sel",     {15'd0, outMuxSelect}, 16'd0);
        // Digit in WAIT_OP is ignored
        tick();
        inDigitValid = 1'b1;
        #1 checkEq("waitop_digit_ignored", {15'd0, outRegLoad}, 16'd0);
        checkEq("waitop_accload_once", {15'd0, outAccLoad}, 16'd0);
        tick();
        idleInputs();
        doOp(2'b01);
        checkEq("waitb_aluop", {14'd0, outAluOp}, 16'd1);
        // Equals in WAIT_B is ignored
        doEquals();
        checkEq("waitb_equals_ignored", {14'd0, outBusy, outDone}, 16'd0);
        inDigitValid = 1'b1;
        #1 checkEq("waitb_digit_regload", {15'd0, outRegLoad}, 16'd1);
        tick();
        idleInputs();
        doEquals();
        for (int i = 0; i < LAT; i++) begin
            checkEq($sformatf("exec%0d_busy_sel_load", i),
                    {13'd0, outBusy, outMuxSelect, outAccLoad}, 16'b110);
            checkEq($sformatf("exec%0d_aluop", i), {14'd0, outAluOp}, 16'd1);
            if (i == 0) begin
                inDigitValid = 1'b1;
                #1 checkEq("exec_digit_ignored", {15'd0, outRegLoad}, 16'd0);
            end
            if (i == 1) begin
                inOpValid = 1'b1;
                inOpCode  = 2'b11;
                inEquals  = 1'b1;
            end
            tick();
            idleInputs();
        end
        checkEq("write_busy_sel_load", {13'd0, outBusy, outMuxSelect, outAccLoad}, 16'b111);
        tick();
        checkEq("done_flag",    {14'd0, outBusy, outDone}, 16'b01);
        checkEq("done_accload", {15'd0, outAccLoad}, 16'd0);
        checkEq("done_opcount", {8'd0, outOpCount},  16'd1);
        checkEq("done_aluop",   {14'd0, outAluOp},   16'd1);

        // Clear from DONE
        doClear();
        checkEq("clr_accclear", {14'd0, outAccClear, outAccLoad}, 16'b10);
        checkEq("clr_opcount",  {8'd0, outOpCount}, 16'd0);
        checkEq("clr_aluop",    {14'd0, outAluOp},  16'd0);
        tick();
        checkEq("clr_one_cycle", {15'd0, outAccClear}, 16'd0);

        // Chain: digit, op=00, digit, op=10, digit, equals
        doDigit();
        tick();
        doOp(2'b00);
        doDigit();
        doOp(2'b10);
        checkEq("chain_exec_aluop", {14'd0, outAluOp}, 16'd0);
        checkEq("chain_exec_busy",  {15'd0, outBusy},  16'd1);
        tick(LAT);
        checkEq("chain_write1", {14'd0, outAccLoad, outMuxSelect}, 16'b11);
        tick();
        checkEq("chain_waitb_aluop", {14'd0, outAluOp}, 16'd2);
        checkEq("chain_waitb_flags", {13'd0, outBusy, outDone, outAccLoad}, 16'd0);
        checkEq("chain_count1", {8'd0, outOpCount}, 16'd1);
        doDigit();
        doEquals();
        checkEq("chain_exec2_aluop", {14'd0, outAluOp}, 16'd2);
        tick(LAT);
        checkEq("chain_write2", {15'd0, outAccLoad}, 16'd1);
        tick();
        checkEq("chain_done",   {15'd0, outDone},   16'd1);
        checkEq("chain_count2", {8'd0, outOpCount}, 16'd2);

        // Clear beats equals in WAIT_EQ
        doOp(2'b11);
        doDigit();
        inClear  = 1'b1;
        inEquals = 1'b1;
        tick();
        idleInputs();
        checkEq("clr_eq_accclear", {15'd0, outAccClear}, 16'd1);
        checkEq("clr_eq_noload",   {15'd0, outAccLoad},  16'd0);
        checkEq("clr_eq_notbusy",  {14'd0, outBusy, outDone}, 16'd0);
        checkEq("clr_eq_idle_op",  {14'd0, outAluOp},  16'd0);
        checkEq("clr_eq_count",    {8'd0, outOpCount}, 16'd0);
        tick();
        checkEq("clr_eq_noload_next", {14'd0, outAccClear, outAccLoad}, 16'd0);

        // Saturation over 260 chained operations
        doDigit();
        tick();
        doOp(2'b01);
        for (int n = 1; n <= 260; n++) begin
            doDigit();
            doOp(2'b10);
            tick(LAT + 1);
            if (n == 254) checkEq("sat_254", {8'd0, outOpCount}, 16'd254);
            if (n == 255) checkEq("sat_255", {8'd0, outOpCount}, 16'd255);
        end
        checkEq("sat_hold", {8'd0, outOpCount}, 16'd255);
        checkEq("sat_waitb", {14'd0, outBusy, outDone}, 16'd0);
        doClear();
        checkEq("sat_clear", {8'd0, outOpCount}, 16'd0);

        // Asynchronous reset in the middle of EXEC
        doDigit();
        tick();
        doOp(2'b01);
        doDigit();
        doEquals();
        tick();
        checkEq("pre_rst_busy", {15'd0, outBusy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        checkEq("async_rst_busy_sel", {14'd0, outBusy, outMuxSelect}, 16'd0);
        checkEq("async_rst_aluop",    {14'd0, outAluOp}, 16'd0);
        checkEq("async_rst_loads",    {13'd0, outAccLoad, outAccClear, outRegLoad}, 16'd0);
        checkEq("async_rst_count",    {8'd0, outOpCount}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        inDigitValid = 1'b1;
        #1 checkEq("post_rst_idle_digit", {15'd0, outRegLoad}, 16'd1);
        tick();
        idleInputs();
        checkEq("post_rst_loada", {15'd0, outAccLoad}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
